// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  Module : imem_pkg
//  Desc   : Shared types and constants for the instruction memory loader.
//  Rev    : 1.0  initial release
// ============================================================================
package imem_pkg;

    localparam int IMEM_ADDR_WIDTH = 5;
    localparam int IMEM_DEPTH      = 2 ** IMEM_ADDR_WIDTH;

    typedef logic [15:0] instr_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GET_COUNT = 3'd1,
        GET_HIGH  = 3'd2,
        GET_LOW   = 3'd3,
        RUN       = 3'd4,
        ERROR     = 3'd5
    } loader_state_t;

    // Compared at 9 bits so a count byte can never alias onto a legal depth.
    function automatic logic count_ok(input logic [7:0] n, input int depth);
        logic [8:0] n9;
        n9 = {1'b0, n};
        return (n9 != 9'd0) && (n9 <= 9'(depth));
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module : imem_loader_if
//  Desc   : Program byte-stream handshake plus the load-start request.
//  Rev    : 1.0  initial release
// ============================================================================
interface imem_loader_if;
    logic       loadStart;
    logic       byteValid;
    logic [7:0] byteData;
    logic       byteReady;

    modport master (output loadStart, output byteValid, output byteData, input  byteReady);
    modport slave  (input  loadStart, input  byteValid, input  byteData, output byteReady);
endinterface
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// ============================================================================
//  Module : imem_array
//  Desc   : Instruction storage: sync write, sync clear, async read.
//  Rev    : 1.0  initial release
// ============================================================================
module imem_array
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = IMEM_ADDR_WIDTH,
    parameter int INSTR_WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    input  wire logic                   we_i,
    input  wire logic [ADDR_WIDTH-1:0]  waddr_i,
    input  wire logic [INSTR_WIDTH-1:0] wdata_i,
    input  wire logic [ADDR_WIDTH-1:0]  raddr_i,
    output logic      [INSTR_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module : imem_loader
//  Desc   : Instruction memory with byte-stream program loader; holds the
//           core in reset until a complete program is resident.
//  Rev    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH  = IMEM_ADDR_WIDTH,
    parameter int INSTR_WIDTH = 16
) (
    input  wire logic                   clk,
    input  wire logic                   reset,
    imem_loader_if.slave                ldr,
    input  wire logic [ADDR_WIDTH-1:0]  currentInstructionAddress,
    output logic      [INSTR_WIDTH-1:0] instruction,
    output logic                        cpuReset,
    output logic                        loadDone,
    output logic                        loadError,
    output logic      [ADDR_WIDTH:0]    loadedCount
);

    localparam int                  DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

    loader_state_t          state_q;
    logic [ADDR_WIDTH-1:0]  word_addr_q;
    logic [7:0]             count_q;
    logic [7:0]             high_q;
    logic                   cpu_reset_q;
    logic                   load_done_q;
    logic                   load_error_q;
    logic [ADDR_WIDTH:0]    loaded_count_q;

    logic                   w_xfer;
    logic                   w_we;
    logic                   w_last_word;
    logic [INSTR_WIDTH-1:0] w_wdata;

    assign ldr.byteReady = (state_q == GET_COUNT) || (state_q == GET_HIGH) ||
                           (state_q == GET_LOW);
    assign w_xfer        = ldr.byteValid && ldr.byteReady;
    assign w_we          = (state_q == GET_LOW) && w_xfer;
    assign w_wdata       = {high_q, ldr.byteData};
    assign w_last_word   = (9'(word_addr_q) + 9'd1) == {1'b0, count_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            word_addr_q    <= '0;
            count_q        <= '0;
            high_q         <= '0;
            cpu_reset_q    <= 1'b1;
            load_done_q    <= 1'b0;
            load_error_q   <= 1'b0;
            loaded_count_q <= '0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                IDLE, RUN, ERROR: begin
                    if (ldr.loadStart) begin
                        state_q        <= GET_COUNT;
                        word_addr_q    <= '0;
                        loaded_count_q <= '0;
                        load_error_q   <= 1'b0;
                        cpu_reset_q    <= 1'b1;
                    end
                end
                GET_COUNT: begin
                    if (w_xfer) begin
                        if (count_ok(ldr.byteData, DEPTH)) begin
                            count_q <= ldr.byteData;
                            state_q <= GET_HIGH;
                        end else begin
                            load_error_q <= 1'b1;
                            state_q      <= ERROR;
                        end
                    end
                end
                GET_HIGH: begin
                    if (w_xfer) begin
                        high_q  <= ldr.byteData;
                        state_q <= GET_LOW;
                    end
                end
                GET_LOW: begin
                    if (w_xfer) begin
                        // A full 32-word load wraps wordAddr to 0, harmless since RUN follows.
                        word_addr_q    <= word_addr_q + ADDR_ONE;
                        loaded_count_q <= loaded_count_q + CNT_ONE;
                        if (w_last_word) begin
                            state_q     <= RUN;
                            cpu_reset_q <= 1'b0;
                            load_done_q <= 1'b1;
                        end else begin
                            state_q <= GET_HIGH;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cpu_reset_q <= 1'b1;
                end
            endcase
        end
    end

    imem_array #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .we_i    (w_we),
        .waddr_i (word_addr_q),
        .wdata_i (w_wdata),
        .raddr_i (currentInstructionAddress),
        .rdata_o (instruction)
    );

    assign cpuReset    = cpu_reset_q;
    assign loadDone    = load_done_q;
    assign loadError   = load_error_q;
    assign loadedCount = loaded_count_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module : tb_imem_loader
//  Desc   : Directed bench for imem_loader: table-driven reads plus sequences.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic [4:0]  pc;
    logic [15:0] instruction;
    logic        cpuReset;
    logic        loadDone;
    logic        loadError;
    logic [5:0]  loadedCount;

    int n_chk;
    int n_fail;
    int done_pulses;
    int cpu_low_cnt;
    logic watch;

    typedef struct {
        logic [4:0]  pc;
        logic [15:0] exp;
    } rd_vec_t;

    rd_vec_t rd_tab[$];

    imem_loader_if ldr ();

    imem_loader #(
        .ADDR_WIDTH  (5),
        .INSTR_WIDTH (16)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .ldr                       (ldr.slave),
        .currentInstructionAddress (pc),
        .instruction               (instruction),
        .cpuReset                  (cpuReset),
        .loadDone                  (loadDone),
        .loadError                 (loadError),
        .loadedCount               (loadedCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (loadDone) done_pulses++;
        if (watch && !cpuReset) cpu_low_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Offers one byte and returns #1 after the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            ldr.byteValid = 1'b0;
            tick();
        end
        ldr.byteValid = 1'b1;
        ldr.byteData  = b;
        for (int c = 0; c < 50 && !ok; c++) begin
            ok = ldr.byteReady;
            tick();
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_byte_timeout: got ready=0, expected ready=1");
        end
    endtask

    task automatic pulse_start();
        ldr.loadStart = 1'b1;
        tick();
        ldr.loadStart = 1'b0;
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < rd_tab.size(); i++) begin
            pc = rd_tab[i].pc;
            #1;
            check($sformatf("%s_pc%0d", nm, rd_tab[i].pc), {16'h0, instruction}, {16'h0, rd_tab[i].exp});
        end
        rd_tab.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses_before;
        n_chk = 0; n_fail = 0; done_pulses = 0; cpu_low_cnt = 0; watch = 1'b0;
        reset = 1'b1; pc = '0;
        ldr.loadStart = 1'b0; ldr.byteValid = 1'b0; ldr.byteData = '0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Reset state
        check("rst_cpuReset",    {31'h0, cpuReset},      32'd1);
        check("rst_byteReady",   {31'h0, ldr.byteReady}, 32'd0);
        check("rst_loadDone",    {31'h0, loadDone},      32'd0);
        check("rst_loadError",   {31'h0, loadError},     32'd0);
        check("rst_loadedCount", {26'h0, loadedCount},   32'd0);
        for (int i = 0; i < 32; i++) rd_tab.push_back('{pc: 5'(i), exp: 16'h0000});
        run_table("rst_mem");

        // Basic two-word load, back to back
        pulse_start();
        check("l1_ready_in_count", {31'h0, ldr.byteReady}, 32'd1);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'hAB, 0);
        check("l1_cpuReset_held", {31'h0, cpuReset}, 32'd1);
        send_byte(8'hCD, 0);
        check("l1_cpuReset_fall", {31'h0, cpuReset},    32'd0);
        check("l1_loadDone_hi",   {31'h0, loadDone},    32'd1);
        check("l1_loadedCount",   {26'h0, loadedCount}, 32'd2);
        ldr.byteValid = 1'b1;
        tick();
        check("l1_loadDone_lo",   {31'h0, loadDone},      32'd0);
        check("l1_ready_in_run",  {31'h0, ldr.byteReady}, 32'd0);
        check("l1_pulses",        done_pulses,            32'd1);
        ldr.byteValid = 1'b0;
        rd_tab.push_back('{pc: 5'd0, exp: 16'h1234});
        rd_tab.push_back('{pc: 5'd1, exp: 16'hABCD});
        rd_tab.push_back('{pc: 5'd2, exp: 16'h0000});
        run_table("l1_mem");

        // Count byte zero
        pulse_start();
        send_byte(8'h00, 0);
        ldr.byteValid = 1'b0;
        check("e0_loadError", {31'h0, loadError},     32'd1);
        check("e0_cpuReset",  {31'h0, cpuReset},      32'd1);
        check("e0_ready",     {31'h0, ldr.byteReady}, 32'd0);

        // Count byte 33, restarted from ERROR
        pulse_start();
        check("e33_err_cleared", {31'h0, loadError}, 32'd0);
        send_byte(8'h21, 0);
        ldr.byteValid = 1'b0;
        check("e33_loadError", {31'h0, loadError}, 32'd1);
        check("e33_cpuReset",  {31'h0, cpuReset},  32'd1);
        rd_tab.push_back('{pc: 5'd0, exp: 16'h1234});
        run_table("e33_mem_kept");

        // Full 32-word load, word i = {i, ~i}
        pulse_start();
        check("f_err_cleared", {31'h0, loadError}, 32'd0);
        send_byte(8'h20, 0);
        for (int i = 0; i < 32; i++) begin
            logic [7:0] hb;
            hb = 8'(i);
            send_byte(hb, 0);
            send_byte(~hb, 0);
        end
        ldr.byteValid = 1'b0;
        check("f_loadedCount", {26'h0, loadedCount},   32'd32);
        check("f_cpuReset",    {31'h0, cpuReset},      32'd0);
        check("f_ready",       {31'h0, ldr.byteReady}, 32'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            logic [7:0] hb;
            hb = 8'(i);
            rd_tab.push_back('{pc: 5'(i), exp: {hb, ~hb}});
        end
        run_table("f_mem");

        // Gapped load with a loadStart pulse during GET_HIGH
        pulses_before = done_pulses;
        pulse_start();
        send_byte(8'h02, 3);
        ldr.byteValid = 1'b0;
        pulse_start();
        check("g_start_ignored", {31'h0, ldr.byteReady}, 32'd1);
        send_byte(8'h12, 3);
        send_byte(8'h34, 3);
        send_byte(8'hAB, 3);
        check("g_cpuReset_held", {31'h0, cpuReset}, 32'd1);
        send_byte(8'hCD, 3);
        ldr.byteValid = 1'b0;
        check("g_loadDone",    {31'h0, loadDone},    32'd1);
        check("g_loadedCount", {26'h0, loadedCount}, 32'd2);
        tick();
        check("g_pulses", done_pulses - pulses_before, 32'd1);
        rd_tab.push_back('{pc: 5'd0, exp: 16'h1234});
        rd_tab.push_back('{pc: 5'd1, exp: 16'hABCD});
        rd_tab.push_back('{pc: 5'd2, exp: 16'h02FD});
        run_table("g_mem");

        // Reset mid-load after one of three words
        pulse_start();
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        ldr.byteValid = 1'b0;
        check("m_loadedCount_pre", {26'h0, loadedCount}, 32'd1);
        reset = 1'b1;
        ldr.loadStart = 1'b1;
        tick();
        reset = 1'b0;
        ldr.loadStart = 1'b0;
        check("m_loadedCount", {26'h0, loadedCount},   32'd0);
        check("m_cpuReset",    {31'h0, cpuReset},      32'd1);
        check("m_ready_idle",  {31'h0, ldr.byteReady}, 32'd0);
        rd_tab.push_back('{pc: 5'd0, exp: 16'h0000});
        rd_tab.push_back('{pc: 5'd1, exp: 16'h0000});
        run_table("m_mem");

        // Reload from RUN
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h11, 0); send_byte(8'h11, 0);
        send_byte(8'h22, 0); send_byte(8'h22, 0);
        ldr.byteValid = 1'b0;
        check("r_pre_run", {31'h0, cpuReset}, 32'd0);
        pulse_start();
        check("r_cpuReset_reassert", {31'h0, cpuReset}, 32'd1);
        watch = 1'b1;
        send_byte(8'h01, 2);
        send_byte(8'hBE, 2);
        send_byte(8'hEF, 2);
        watch = 1'b0;
        ldr.byteValid = 1'b0;
        check("r_cpu_low_cycles", cpu_low_cnt,           32'd0);
        check("r_cpuReset_fall",  {31'h0, cpuReset},     32'd0);
        check("r_loadedCount",    {26'h0, loadedCount},  32'd1);
        rd_tab.push_back('{pc: 5'd0, exp: 16'hBEEF});
        rd_tab.push_back('{pc: 5'd1, exp: 16'h2222});
        run_table("r_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction memory for the single-cycle core, plus a byte-stream loader that writes it.
- The datapath reads the 16-bit instruction at the 5-bit PC. This block is the writer side of that interface.
- It accepts a program over a valid/ready byte handshake and packs byte pairs into instruction words.
- It holds the core in reset until a complete program has been loaded.

Parameters:
- ADDR_WIDTH, 5, instruction address width; depth is 2**ADDR_WIDTH words.
- INSTR_WIDTH, 16, instruction word width; fixed at two bytes, high byte first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- loadStart  in  1  single-cycle request to begin a new program load.
- byteValid  in  1  byteData holds a valid byte.
- byteData  in  8  program stream byte.
- byteReady  out  1  loader accepts a byte this cycle; a byte transfers when byteValid && byteReady.
- currentInstructionAddress  in  ADDR_WIDTH  PC from the datapath.
- instruction  out  INSTR_WIDTH  combinational read, mem[currentInstructionAddress].
- cpuReset  out  1  registered; holds the core and register file in reset.
- loadDone  out  1  registered one-cycle pulse when a load completes.
- loadError  out  1  registered level; the last load was rejected because of a bad count byte.
- loadedCount  out  ADDR_WIDTH+1  number of words written by the current or last load.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; all memory words cleared to 16'h0000.
  - cpuReset=1, loadDone=0, loadError=0, loadedCount=0, byteReady=0.
- States: IDLE, GET_COUNT, GET_HIGH, GET_LOW, RUN, ERROR. One-hot or binary encoding is an implementer choice.
- IDLE, RUN, ERROR:
  - byteReady=0; bytes offered are not consumed.
  - loadStart -> GET_COUNT.
  - On that transition: wordAddr=0, loadedCount=0, loadError cleared.
- GET_COUNT:
  - byteReady=1.
  - On transfer, count N=byteData.
  - If N==0 or N>2**ADDR_WIDTH -> ERROR, loadError=1.
  - Otherwise latch N -> GET_HIGH.
- GET_HIGH:
  - byteReady=1.
  - On transfer, latch the high byte -> GET_LOW.
- GET_LOW:
  - byteReady=1.
  - On transfer, write mem[wordAddr] = {highByte, byteData}; wordAddr++, loadedCount++.
  - If wordAddr==N-1 -> RUN; else -> GET_HIGH.
- Register outputs:
  - byteReady is decoded from the registered state.
  - cpuReset = (next state != RUN), registered, so cpuReset falls on the same edge that enters RUN.
  - loadDone pulses high for exactly the first RUN cycle.
- Memory:
  - Words at addresses >= N keep their previous contents; they are not cleared.
  - Writes take effect at the clock edge. A same-cycle read at the write address returns the old word.
- Boundary conditions:
  - loadStart during GET_COUNT/GET_HIGH/GET_LOW is ignored; the load in progress continues.
  - N==32 fills every address. wordAddr wraps 31->0 internally but RUN is entered first, so no overwrite occurs.
  - byteValid low in any GET_* state: hold state; no stall timeout.
  - Reset asserted mid-load: abort immediately, clear memory, go to IDLE with cpuReset=1.
  - loadStart and reset in the same cycle: reset wins.
  - loadStart from RUN re-asserts cpuReset on the same edge that enters GET_COUNT. Program memory is rewritten while the core is held.
- Arithmetic:
  - wordAddr is ADDR_WIDTH bits.
  - loadedCount is ADDR_WIDTH+1 bits so that the value 32 is representable.
  - The N comparison is done at 9-bit width to avoid truncation.

Decomposition:
- Shared package imem_pkg:
  - typedef enum loader_state_t {IDLE, GET_COUNT, GET_HIGH, GET_LOW, RUN, ERROR}.
  - constant IMEM_DEPTH = 2**ADDR_WIDTH.
  - typedef instr_t = logic [15:0].
- Sub-module imem_array:
  - 2**ADDR_WIDTH x INSTR_WIDTH storage, synchronous write, synchronous clear on reset, asynchronous read port.
  - The loader FSM stays in imem_loader.

Test Plan:
- Reset then idle 5 cycles -> cpuReset=1, byteReady=0, instruction=16'h0000 for every PC value, loadDone=0.
- loadStart, then bytes 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD with byteValid held high:
  - mem[0]=16'h1234, mem[1]=16'hABCD.
  - loadDone pulses once, on the cycle cpuReset falls; loadedCount=2.
  - Driving PC=1 shows 16'hABCD.
- Count byte 8'h00 -> ERROR, loadError=1, cpuReset=1.
- Count byte 8'h21 (33) -> ERROR, loadError=1, cpuReset=1.
- A subsequent valid loadStart clears loadError.
- Load N=32 with word i = {i, ~i}:
  - All 32 addresses match; loadedCount=6'd32.
  - mem[0] is not overwritten; state=RUN.
- Mid-load events:
  - byteValid gaps of 3 cycles between bytes -> identical result to the back-to-back case.
  - A loadStart pulse during GET_HIGH is ignored.
- Reset after writing 1 of 3 words -> state=IDLE, mem[0]=16'h0000, loadedCount=0, cpuReset=1.
- Reload while in RUN:
  - Reload N=1 with 16'hBEEF -> mem[0]=16'hBEEF; mem[1] keeps the word from the prior load.
  - cpuReset is high through the whole reload.
